tx_burst_scheduler: RTL and testbench

Controller that sequences signal_gen for burst transmission. Starts each frame, paces sample release at a programmable DAC rate via signal_gen's enable handshake, and acknowledges end-of-frame. Inserts inter-frame gaps, repeats frames, and handles abort. Sits between the host/config registers and signal_gen; its registered I/Q output feeds the DAC interface.

---
 rtl/tx_burst_scheduler.sv | 190 +++++++++++++++++++
 tb/tb_tx_burst_scheduler.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_burst_scheduler.sv
// Burst sequencer for signal_gen: starts each frame, releases samples at a programmable DAC
// rate, acknowledges end-of-frame, inserts inter-frame gaps, repeats frames and handles abort.
module tx_burst_scheduler #(
  parameter int unsigned SAMPLE_W = 13,
  parameter int unsigned DIV_W    = 16,
  parameter int unsigned MIN_DIV  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [7:0]          repeat_count,
  input  logic [DIV_W-1:0]    gap_cycles,
  input  logic [DIV_W-1:0]    sample_div,
  input  logic                gen_valid,
  input  logic                gen_done,
  input  logic [SAMPLE_W-1:0] gen_i,
  input  logic [SAMPLE_W-1:0] gen_q,
  output logic                gen_enable,
  output logic                gen_reset,
  output logic [SAMPLE_W-1:0] dac_i,
  output logic [SAMPLE_W-1:0] dac_q,
  output logic                dac_strobe,
  output logic                busy,
  output logic                frame_done,
  output logic [7:0]          frames_sent,
  output logic                underrun
);

  localparam logic [DIV_W-1:0] MinDiv = DIV_W'(MIN_DIV);
  localparam logic [DIV_W-1:0] One    = DIV_W'(1);

  typedef enum logic [2:0] {StIdle, StStart, StRun, StAck, StGap, StFin} state_e;

  state_e              state_q, state_d;
  logic [7:0]          rpt_q, rpt_d;
  logic [DIV_W-1:0]    gap_q, gap_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [DIV_W-1:0]    tick_cnt_q, tick_cnt_d;
  logic [DIV_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic [7:0]          frames_q, frames_d;
  logic                underrun_q, underrun_d;
  logic [SAMPLE_W-1:0] dac_i_q, dac_i_d;
  logic [SAMPLE_W-1:0] dac_q_q, dac_q_d;
  logic                dac_strobe_q, dac_strobe_d;
  logic                frame_done_q, frame_done_d;
  logic                gen_reset_q, gen_reset_d;

  logic       active;
  logic       tick;
  logic [7:0] frames_inc;

  assign active     = (state_q != StIdle);
  assign tick       = (tick_cnt_q == div_q - One);
  assign frames_inc = frames_q + 8'd1;

  always_comb begin
    state_d      = state_q;
    rpt_d        = rpt_q;
    gap_d        = gap_q;
    div_d        = div_q;
    tick_cnt_d   = '0;
    gap_cnt_d    = gap_cnt_q;
    frames_d     = frames_q;
    underrun_d   = underrun_q;
    dac_i_d      = dac_i_q;
    dac_q_d      = dac_q_q;
    dac_strobe_d = 1'b0;
    frame_done_d = 1'b0;
    gen_reset_d  = 1'b0;
    gen_enable   = 1'b0;

    // Abort overrides everything; the aborted frame is never acknowledged.
    if (abort && active) begin
      state_d     = StIdle;
      gen_reset_d = 1'b1;
      dac_i_d     = '0;
      dac_q_d     = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start && !abort) begin
            rpt_d      = repeat_count;
            gap_d      = gap_cycles;
            div_d      = (sample_div < MinDiv) ? MinDiv : sample_div;
            frames_d   = '0;
            underrun_d = 1'b0;
            state_d    = StStart;
          end
        end
        StStart: begin
          gen_enable = 1'b1;
          state_d    = StRun;
        end
        StRun: begin
          if (gen_done) begin
            state_d = StAck;
          end else begin
            tick_cnt_d = tick ? '0 : tick_cnt_q + One;
            if (tick) begin
              dac_strobe_d = 1'b1;
              if (gen_valid) begin
                gen_enable = 1'b1;
                dac_i_d    = gen_i;
                dac_q_d    = gen_q;
              end else begin
                underrun_d = 1'b1;
              end
            end
          end
        end
        StAck: begin
          // Single enable here only returns signal_gen from DONE to INITIAL.
          gen_enable   = 1'b1;
          frame_done_d = 1'b1;
          frames_d     = frames_inc;
          gap_cnt_d    = '0;
          if (rpt_q != 8'd0 && frames_inc == rpt_q) begin
            state_d = StFin;
            dac_i_d = '0;
            dac_q_d = '0;
          end else if (gap_q == '0) begin
            state_d = StStart;
          end else begin
            state_d = StGap;
            dac_i_d = '0;
            dac_q_d = '0;
          end
        end
        StGap: begin
          tick_cnt_d   = tick ? '0 : tick_cnt_q + One;
          dac_strobe_d = tick;
          if (gap_cnt_q == gap_q - One) begin
            state_d = StStart;
          end else begin
            gap_cnt_d = gap_cnt_q + One;
          end
        end
        StFin: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      rpt_q        <= '0;
      gap_q        <= '0;
      div_q        <= '0;
      tick_cnt_q   <= '0;
      gap_cnt_q    <= '0;
      frames_q     <= '0;
      underrun_q   <= 1'b0;
      dac_i_q      <= '0;
      dac_q_q      <= '0;
      dac_strobe_q <= 1'b0;
      frame_done_q <= 1'b0;
      gen_reset_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rpt_q        <= rpt_d;
      gap_q        <= gap_d;
      div_q        <= div_d;
      tick_cnt_q   <= tick_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      frames_q     <= frames_d;
      underrun_q   <= underrun_d;
      dac_i_q      <= dac_i_d;
      dac_q_q      <= dac_q_d;
      dac_strobe_q <= dac_strobe_d;
      frame_done_q <= frame_done_d;
      gen_reset_q  <= gen_reset_d;
    end
  end

  assign gen_reset   = gen_reset_q;
  assign dac_i       = dac_i_q;
  assign dac_q       = dac_q_q;
  assign dac_strobe  = dac_strobe_q;
  assign busy        = active;
  assign frame_done  = frame_done_q;
  assign frames_sent = frames_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_tx_burst_scheduler.sv
// Directed bench for tx_burst_scheduler with a small behavioural signal_gen model.
module tb_tx_burst_scheduler;

  logic        clk = 1'b0;
  logic        reset, start, abort;
  logic [7:0]  repeat_count;
  logic [15:0] gap_cycles, sample_div;
  logic        gen_valid, gen_done;
  logic [12:0] gen_i, gen_q;
  logic        gen_enable, gen_reset, dac_strobe, busy, frame_done, underrun;
  logic [12:0] dac_i, dac_q;
  logic [7:0]  frames_sent;

  int errors = 0;
  int checks = 0;
  int en_cnt = 0, fd_cnt = 0, grst_cnt = 0;
  int m_len = 4, m_stall_at = -1, m_stall_len = 0, m_stall = 0;
  int m_k = 0, m_starts = 0, m_viol = 0;
  typedef enum {MInit, MRun, MDone} mst_e;
  mst_e m_st = MInit;

  tx_burst_scheduler #(.SAMPLE_W(13), .DIV_W(16), .MIN_DIV(8)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .repeat_count(repeat_count), .gap_cycles(gap_cycles), .sample_div(sample_div),
    .gen_valid(gen_valid), .gen_done(gen_done), .gen_i(gen_i), .gen_q(gen_q),
    .gen_enable(gen_enable), .gen_reset(gen_reset), .dac_i(dac_i), .dac_q(dac_q),
    .dac_strobe(dac_strobe), .busy(busy), .frame_done(frame_done),
    .frames_sent(frames_sent), .underrun(underrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (gen_enable === 1'b1) en_cnt <= en_cnt + 1;
    if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;
    if (gen_reset === 1'b1)  grst_cnt <= grst_cnt + 1;
  end

  task automatic present(input int k);
    gen_i = 13'(7 * k + 1);
    gen_q = 13'(8000 - 3 * k);
  endtask

  // signal_gen model: enable in INITIAL starts a frame, enable with valid advances,
  // enable in DONE returns to INITIAL. Decisions use gen_enable as sampled before the edge.
  initial begin : model
    logic en, rs;
    gen_valid = 1'b0;
    gen_done  = 1'b0;
    gen_i     = '0;
    gen_q     = '0;
    forever begin
      @(negedge clk);
      en = gen_enable;
      rs = gen_reset;
      @(posedge clk);
      #2;
      if (reset || rs === 1'b1) begin
        gen_valid = 1'b0;
        gen_done  = 1'b0;
        m_stall   = 0;
        m_st      = MInit;
      end else if (en === 1'b1) begin
        case (m_st)
          MInit: begin
            m_k = 0;
            present(0);
            gen_valid = 1'b1;
            m_st = MRun;
            m_starts++;
          end
          MRun: begin
            if (!gen_valid) begin
              m_viol++;
            end else begin
              m_k++;
              if (m_k == m_len) begin
                gen_valid = 1'b0;
                gen_done  = 1'b1;
                m_st      = MDone;
              end else begin
                present(m_k);
                if (m_k - 1 == m_stall_at) begin
                  gen_valid = 1'b0;
                  m_stall   = m_stall_len;
                end
              end
            end
          end
          default: begin
            gen_done = 1'b0;
            m_st     = MInit;
          end
        endcase
      end else if (m_stall > 0) begin
        m_stall--;
        if (m_stall == 0) gen_valid = 1'b1;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic sel(input int w);
    case (w)
      0:       return dac_strobe;
      1:       return frame_done;
      default: return !busy;
    endcase
  endfunction

  task automatic wait_for(input int w, input int bound, input string tag, output time t);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (sel(w) !== 1'b1 && n < bound);
    chk(tag, 32'(sel(w)), 32'd1);
    t = $time;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_abort();
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    @(negedge clk);
  endtask

  initial begin : stim
    time t0, t1, t2, t3;
    int e0, f0, s0, g0;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    repeat_count = '0; gap_cycles = '0; sample_div = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_dac_i", 32'(dac_i), 0);
    chk("rst_strobe", 32'(dac_strobe), 0);
    chk("rst_frames", 32'(frames_sent), 0);
    chk("rst_underrun", 32'(underrun), 0);
    chk("rst_gen_en", 32'(gen_enable), 0);
    chk("rst_gen_rst", 32'(gen_reset), 0);
    @(posedge clk); #1 reset = 1'b0;

    // 1: single frame of 4 samples, div 10
    repeat_count = 8'd1; sample_div = 16'd10; gap_cycles = 16'd0; m_len = 4;
    @(posedge clk); e0 = en_cnt; f0 = fd_cnt;
    pulse_start();
    chk("t1_start_en", 32'(gen_enable), 1);
    chk("t1_busy", 32'(busy), 1);
    t0 = $time;
    wait_for(0, 40, "t1_strobe_seen", t1);
    chk("t1_first_lat", 32'((t1 - t0) / 10), 11);
    chk("t1_i0", 32'(dac_i), 1);
    chk("t1_q0", 32'(dac_q), 8000);
    for (int k = 1; k < 4; k++) begin
      t0 = t1;
      wait_for(0, 40, "t1_strobe_seen", t1);
      chk("t1_spacing", 32'((t1 - t0) / 10), 10);
      chk("t1_i", 32'(dac_i), 32'(7 * k + 1));
      chk("t1_q", 32'(dac_q), 32'(8000 - 3 * k));
    end
    wait_for(1, 40, "t1_fd_seen", t2);
    chk("t1_fd_lat", 32'((t2 - t1) / 10), 2);
    chk("t1_frames", 32'(frames_sent), 1);
    chk("t1_busy_fin", 32'(busy), 1);
    chk("t1_dac_zero_fin", 32'(dac_i), 0);
    @(negedge clk);
    chk("t1_busy_low", 32'(busy), 0);
    @(posedge clk);
    chk("t1_en_pulses", 32'(en_cnt - e0), 6);
    chk("t1_fd_count", 32'(fd_cnt - f0), 1);

    // 2: three frames with a 20-clock gap
    repeat_count = 8'd3; gap_cycles = 16'd20; m_len = 2;
    @(posedge clk); e0 = en_cnt; s0 = m_starts;
    pulse_start();
    t0 = $time;
    wait_for(1, 60, "t2_fd1_seen", t1);
    chk("t2_fd1_lat", 32'((t1 - t0) / 10), 23);
    chk("t2_frames1", 32'(frames_sent), 1);
    wait_for(0, 40, "t2_gap_strobe_seen", t2);
    chk("t2_gap_strobe_lat", 32'((t2 - t1) / 10), 10);
    chk("t2_gap_i", 32'(dac_i), 0);
    chk("t2_gap_q", 32'(dac_q), 0);
    wait_for(1, 80, "t2_fd2_seen", t3);
    chk("t2_frame_period", 32'((t3 - t1) / 10), 43);
    chk("t2_frames2", 32'(frames_sent), 2);
    t1 = t3;
    wait_for(1, 80, "t2_fd3_seen", t3);
    chk("t2_frame_period", 32'((t3 - t1) / 10), 43);
    chk("t2_frames3", 32'(frames_sent), 3);
    @(negedge clk);
    chk("t2_busy_low", 32'(busy), 0);
    @(posedge clk);
    chk("t2_starts", 32'(m_starts - s0), 3);
    chk("t2_en_pulses", 32'(en_cnt - e0), 12);

    // 3: sample_div below the minimum is clamped; mid-burst changes ignored
    repeat_count = 8'd1; gap_cycles = 16'd0; sample_div = 16'd3; m_len = 3;
    @(posedge clk); s0 = m_starts;
    pulse_start();
    t0 = $time;
    sample_div = 16'd20;
    wait_for(0, 40, "t3_strobe_seen", t1);
    chk("t3_first_lat", 32'((t1 - t0) / 10), 9);
    pulse_start();
    wait_for(0, 40, "t3_strobe_seen", t2);
    chk("t3_spacing", 32'((t2 - t1) / 10), 8);
    wait_for(0, 40, "t3_strobe_seen", t3);
    chk("t3_spacing", 32'((t3 - t2) / 10), 8);
    wait_for(2, 40, "t3_idle_seen", t3);
    chk("t3_frames", 32'(frames_sent), 1);
    @(posedge clk);
    chk("t3_starts", 32'(m_starts - s0), 1);

    // 4: generator withholds valid across two ticks
    sample_div = 16'd10; m_len = 4; m_stall_at = 0; m_stall_len = 25;
    pulse_start();
    wait_for(0, 40, "t4_strobe_seen", t1);
    chk("t4_i0", 32'(dac_i), 1);
    chk("t4_underrun0", 32'(underrun), 0);
    wait_for(0, 40, "t4_strobe_seen", t2);
    chk("t4_miss_spacing", 32'((t2 - t1) / 10), 10);
    chk("t4_hold1", 32'(dac_i), 1);
    chk("t4_underrun1", 32'(underrun), 1);
    wait_for(0, 40, "t4_strobe_seen", t3);
    chk("t4_miss_spacing", 32'((t3 - t2) / 10), 10);
    chk("t4_hold2", 32'(dac_i), 1);
    wait_for(0, 40, "t4_strobe_seen", t3);
    chk("t4_i1", 32'(dac_i), 8);
    wait_for(2, 100, "t4_idle_seen", t3);
    chk("t4_underrun_sticky", 32'(underrun), 1);
    m_stall_at = -1;

    // 5: abort in the second frame after two samples, then restart at once
    repeat_count = 8'd2; m_len = 4;
    @(posedge clk); f0 = fd_cnt; g0 = grst_cnt;
    pulse_start();
    chk("t5_underrun_clr", 32'(underrun), 0);
    chk("t5_frames_clr", 32'(frames_sent), 0);
    wait_for(1, 80, "t5_fd_seen", t1);
    chk("t5_frames1", 32'(frames_sent), 1);
    wait_for(0, 40, "t5_strobe_seen", t1);
    wait_for(0, 40, "t5_strobe_seen", t1);
    chk("t5_i1", 32'(dac_i), 8);
    pulse_abort();
    chk("t5_gen_reset", 32'(gen_reset), 1);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_dac_i", 32'(dac_i), 0);
    chk("t5_dac_q", 32'(dac_q), 0);
    chk("t5_frames_held", 32'(frames_sent), 1);
    chk("t5_no_fd", 32'(frame_done), 0);
    @(negedge clk);
    chk("t5_gen_reset_end", 32'(gen_reset), 0);
    repeat_count = 8'd1;
    pulse_start();
    chk("t5_restart_busy", 32'(busy), 1);
    chk("t5_restart_frames", 32'(frames_sent), 0);
    wait_for(1, 80, "t5_fd2_seen", t1);
    chk("t5_restart_frames1", 32'(frames_sent), 1);
    wait_for(2, 40, "t5_idle_seen", t1);
    @(posedge clk);
    chk("t5_grst_count", 32'(grst_cnt - g0), 1);
    chk("t5_fd_count", 32'(fd_cnt - f0), 2);

    // Simultaneous start and abort while idle: stay idle
    @(posedge clk); #1 start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("sa_busy", 32'(busy), 0);
    chk("sa_gen_reset", 32'(gen_reset), 0);

    // 6: continuous mode, 300 tiny frames, wrap then abort
    repeat_count = 8'd0; sample_div = 16'd0; gap_cycles = 16'd0; m_len = 1;
    @(posedge clk); f0 = fd_cnt;
    pulse_start();
    for (int i = 1; i <= 300; i++) begin
      wait_for(1, 40, "t6_fd_seen", t1);
      if (i == 255) chk("t6_frames255", 32'(frames_sent), 255);
      if (i == 256) begin
        chk("t6_frames_wrap", 32'(frames_sent), 0);
        chk("t6_busy_after_wrap", 32'(busy), 1);
      end
    end
    chk("t6_frames300", 32'(frames_sent), 44);
    pulse_abort();
    chk("t6_busy_abort", 32'(busy), 0);
    chk("t6_frames_held", 32'(frames_sent), 44);
    repeat (30) @(negedge clk);
    @(posedge clk);
    chk("t6_fd_count", 32'(fd_cnt - f0), 300);
    chk("t6_still_idle", 32'(busy), 0);

    chk("model_protocol", 32'(m_viol), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
